// File: rtl/pio_event_sequencer_pkg.sv
// Shared constants and types for the PIO event sequencer: PIO register map,
// FSM state encoding and the queued {edges, level} event record.
package pio_evt_pkg;

  localparam int unsigned PIO_WIDTH = 10;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    INIT_MASK = 3'd0,
    IDLE      = 3'd1,
    RD_EDGE_A = 3'd2,
    RD_EDGE_D = 3'd3,
    CLR_EDGE  = 3'd4,
    RD_LVL_A  = 3'd5,
    RD_LVL_D  = 3'd6,
    PUSH      = 3'd7
  } state_e;

  typedef struct packed {
    logic [PIO_WIDTH-1:0] edges;
    logic [PIO_WIDTH-1:0] level;
  } ev_rec_t;

endpackage

// File: rtl/pio_event_sequencer_if.sv
// PIO slave bus plus the event-record valid/ready stream, seen from the
// sequencer (master) and from the PIO/consumer side (slave).
interface pio_event_sequencer_if
  import pio_evt_pkg::*;
#(
  parameter int unsigned WIDTH = PIO_WIDTH
);
  logic [1:0]       pio_address;
  logic             pio_chipselect;
  logic             pio_write_n;
  logic [31:0]      pio_writedata;
  logic [31:0]      pio_readdata;
  logic             pio_irq;
  logic             ev_valid;
  logic [WIDTH-1:0] ev_edges;
  logic [WIDTH-1:0] ev_level;
  logic             ev_ready;

  modport master (
    output pio_address, pio_chipselect, pio_write_n, pio_writedata,
    output ev_valid, ev_edges, ev_level,
    input  pio_readdata, pio_irq, ev_ready
  );

  modport slave (
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
    input  ev_valid, ev_edges, ev_level,
    output pio_readdata, pio_irq, ev_ready
  );
endinterface

// File: rtl/pio_event_sequencer_fifo.sv
// First-word-fall-through event FIFO. A push while full is accepted only when
// a pop happens in the same cycle; a pop while empty is ignored.
module pio_event_fifo #(
  parameter int unsigned W     = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  // Head is forced to zero when empty so the record outputs read zero after reset.
  assign pop_data  = empty ? '0 : mem_r[rd_ptr_r];

  // Record storage; when full with a pop, the write lands on the slot being vacated.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/pio_event_sequencer.sv
// Bus master that services the edge-capture PIO on irq and queues one
// {edges, level} record per event for a valid/ready consumer.
module pio_event_sequencer
  import pio_evt_pkg::*;
#(
  parameter int unsigned      WIDTH    = PIO_WIDTH,
  parameter logic [WIDTH-1:0] IRQ_MASK = 10'h3FF,
  parameter int unsigned      DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pio_event_sequencer_if.master bus,
  output logic                  overflow,
  input  logic                  overflow_clr
);
  state_e           state_r;
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH-1:0] level_r;
  logic [WIDTH-1:0] rd_s;
  logic             rd_unused_s;
  logic             push_s;
  logic             drop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  ev_rec_t          push_rec_s;
  ev_rec_t          head_s;

  assign rd_s        = bus.pio_readdata[WIDTH-1:0];
  assign rd_unused_s = ^bus.pio_readdata[31:WIDTH];
  assign push_s      = (state_r == PUSH);
  // When full, only a same-cycle pop makes room for the new record.
  assign drop_s      = push_s && fifo_full_s && !bus.ev_ready;
  assign push_rec_s  = '{edges: edge_r, level: level_r};

  // Sequencer FSM; bus outputs are loaded together with the next state so they
  // are active during the cycle that state is current.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r            <= INIT_MASK;
      bus.pio_address    <= PIO_ADDR_DATA;
      bus.pio_chipselect <= 1'b0;
      bus.pio_write_n    <= 1'b1;
      bus.pio_writedata  <= 32'h0000_0000;
      edge_r             <= '0;
      level_r            <= '0;
    end else begin
      bus.pio_chipselect <= 1'b0;
      bus.pio_write_n    <= 1'b1;
      bus.pio_writedata  <= 32'h0000_0000;
      case (state_r)
        INIT_MASK: begin
          bus.pio_address    <= PIO_ADDR_MASK;
          bus.pio_chipselect <= 1'b1;
          bus.pio_write_n    <= 1'b0;
          bus.pio_writedata  <= 32'(IRQ_MASK);
          state_r            <= IDLE;
        end
        IDLE: begin
          if (bus.pio_irq) begin
            bus.pio_address    <= PIO_ADDR_EDGE;
            bus.pio_chipselect <= 1'b1;
            state_r            <= RD_EDGE_A;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_EDGE_A: state_r <= RD_EDGE_D;
        RD_EDGE_D: begin
          edge_r <= rd_s;
          if (rd_s == '0) begin
            state_r <= IDLE;
          end else begin
            bus.pio_address    <= PIO_ADDR_EDGE;
            bus.pio_chipselect <= 1'b1;
            bus.pio_write_n    <= 1'b0;
            state_r            <= CLR_EDGE;
          end
        end
        CLR_EDGE: begin
          bus.pio_address    <= PIO_ADDR_DATA;
          bus.pio_chipselect <= 1'b1;
          state_r            <= RD_LVL_A;
        end
        RD_LVL_A: state_r <= RD_LVL_D;
        RD_LVL_D: begin
          level_r <= rd_s;
          state_r <= PUSH;
        end
        PUSH:    state_r <= IDLE;
        default: state_r <= INIT_MASK;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop_s) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

  pio_event_fifo #(
    .W     ($bits(ev_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_rec_s),
    .pop       (bus.ev_ready),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign bus.ev_valid = !fifo_empty_s;
  assign bus.ev_edges = head_s.edges;
  assign bus.ev_level = head_s.level;
endmodule

// File: tb/tb_pio_event_sequencer.sv
// Bench for pio_event_sequencer: PIO behavioural model, event scoreboard with
// a decoupled record monitor, and directed plus randomized event stimulus.
module tb_pio_event_sequencer;
  import pio_evt_pkg::*;

  localparam int unsigned W     = 10;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [W-1:0] edges;
    logic [W-1:0] level;
  } rec_t;

  typedef struct {
    int          stamp;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] data;
  } op_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic overflow;
  logic overflow_clr = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pops = 0;
  bit   exp_ovf = 1'b0;
  rec_t exp_q[$];
  op_t  ops[$];

  pio_event_sequencer_if #(.WIDTH(W)) bus_if ();

  pio_event_sequencer #(
    .WIDTH    (W),
    .IRQ_MASK (10'h3FF),
    .DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PIO model: any-edge capture, write to reg 3 clears capture, registered read data.
  logic [W-1:0] in_port = '0;
  logic [W-1:0] prev_in = '0;
  logic [W-1:0] cap = '0;
  logic [W-1:0] mask = '0;
  logic         spur = 1'b0;

  always @(posedge clk) begin
    prev_in <= in_port;
    if (bus_if.pio_chipselect && !bus_if.pio_write_n && bus_if.pio_address == PIO_ADDR_EDGE)
      cap <= in_port ^ prev_in;
    else
      cap <= cap | (in_port ^ prev_in);
    if (bus_if.pio_chipselect && !bus_if.pio_write_n && bus_if.pio_address == PIO_ADDR_MASK)
      mask <= bus_if.pio_writedata[W-1:0];
    case (bus_if.pio_address)
      PIO_ADDR_DATA: bus_if.pio_readdata <= {22'd0, in_port};
      PIO_ADDR_MASK: bus_if.pio_readdata <= {22'd0, mask};
      PIO_ADDR_EDGE: bus_if.pio_readdata <= {22'd0, cap};
      default:       bus_if.pio_readdata <= 32'd0;
    endcase
  end
  assign bus_if.pio_irq = (|(cap & mask)) | spur;

  logic rand_mode = 1'b0;
  logic rand_ready = 1'b0;
  logic ready_dir = 1'b0;
  assign bus_if.ev_ready = rand_mode ? rand_ready : ready_dir;

  initial forever begin
    @(posedge clk);
    #1 rand_ready = ($urandom_range(3) != 0);
  end

  always @(negedge clk) begin
    if (bus_if.pio_chipselect)
      ops.push_back('{cyc, bus_if.pio_write_n, bus_if.pio_address, bus_if.pio_writedata});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted head record is compared with the oldest expected one.
  initial begin : monitor
    rec_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus_if.ev_valid && bus_if.ev_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("unexpected_record", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rec_edges", 32'(bus_if.ev_edges), 32'(e.edges));
          check("rec_level", 32'(bus_if.ev_level), 32'(e.level));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready_dir = v;
  endtask

  // Reference: a toggle yields edges = flipped bits and level = new inputs,
  // kept if fewer than DEPTH records are waiting (or one leaves as it lands).
  task automatic issue_event(input logic [W-1:0] flip, input bit pop_at_push, input bit record);
    @(negedge clk);
    in_port = in_port ^ flip;
    if (record) begin
      if (exp_q.size() < DEPTH || pop_at_push) exp_q.push_back({flip, in_port});
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic check_mask_write(input int c0);
    check("init_op_count", 32'(ops.size()), 32'd1);
    if (ops.size() >= 1) begin
      check("init_stamp", 32'(ops[0].stamp), 32'(c0 + 1));
      check("init_write_n", 32'(ops[0].wn), 32'd0);
      check("init_addr", 32'(ops[0].addr), 32'(PIO_ADDR_MASK));
      check("init_data", ops[0].data, 32'h0000_03FF);
    end
  endtask

  initial begin : main
    int c0;
    int p0;
    // Reset state
    tick(3);
    check("rst_addr", 32'(bus_if.pio_address), 32'd0);
    check("rst_cs", 32'(bus_if.pio_chipselect), 32'd0);
    check("rst_write_n", 32'(bus_if.pio_write_n), 32'd1);
    check("rst_wdata", bus_if.pio_writedata, 32'd0);
    check("rst_valid", 32'(bus_if.ev_valid), 32'd0);
    check("rst_edges", 32'(bus_if.ev_edges), 32'd0);
    check("rst_level", 32'(bus_if.ev_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    ops.delete();
    reset = 1'b0;
    c0 = cyc;
    tick(6);
    check_mask_write(c0);

    // Single toggle of bit 3: bus sequence and latency
    ops.delete();
    issue_event(10'h008, 1'b0, 1'b1);
    c0 = cyc;
    tick(7);
    check("valid_t6", 32'(bus_if.ev_valid), 32'd0);
    tick(1);
    check("valid_t7", 32'(bus_if.ev_valid), 32'd1);
    check("seq_op_count", 32'(ops.size()), 32'd3);
    if (ops.size() == 3) begin
      check("rd_edge_stamp", 32'(ops[0].stamp), 32'(c0 + 2));
      check("rd_edge_op", {29'd0, ops[0].wn, ops[0].addr}, {29'd0, 1'b1, PIO_ADDR_EDGE});
      check("clr_stamp", 32'(ops[1].stamp), 32'(c0 + 4));
      check("clr_op", {29'd0, ops[1].wn, ops[1].addr}, {29'd0, 1'b0, PIO_ADDR_EDGE});
      check("clr_data", ops[1].data, 32'd0);
      check("rd_lvl_stamp", 32'(ops[2].stamp), 32'(c0 + 5));
      check("rd_lvl_op", {29'd0, ops[2].wn, ops[2].addr}, {29'd0, 1'b1, PIO_ADDR_DATA});
    end
    set_ready(1'b1);
    tick(3);
    check("toggle_drained", 32'(exp_q.size()), 32'd0);

    // Spurious irq: one edge read, no clear, no record
    ops.delete();
    @(negedge clk);
    spur = 1'b1;
    c0 = cyc;
    @(negedge clk);
    spur = 1'b0;
    tick(10);
    check("spur_op_count", 32'(ops.size()), 32'd1);
    if (ops.size() >= 1) begin
      check("spur_stamp", 32'(ops[0].stamp), 32'(c0 + 1));
      check("spur_op", {29'd0, ops[0].wn, ops[0].addr}, {29'd0, 1'b1, PIO_ADDR_EDGE});
    end
    check("spur_valid", 32'(bus_if.ev_valid), 32'd0);

    // Five events with no consumer: four kept, one dropped
    set_ready(1'b0);
    for (int i = 0; i < 5; i++) begin
      issue_event(W'($urandom_range(1, 1023)), 1'b0, 1'b1);
      tick(10);
    end
    check("ovf_set", 32'(overflow), 32'(exp_ovf));
    check("ovf_valid", 32'(bus_if.ev_valid), 32'd1);
    @(negedge clk);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_clear", 32'(overflow), 32'(exp_ovf));

    // Full FIFO, push and pop in the PUSH cycle
    issue_event(W'($urandom_range(1, 1023)), 1'b1, 1'b1);
    repeat (7) @(posedge clk);
    #1 ready_dir = 1'b1;
    @(posedge clk);
    #1 ready_dir = 1'b0;
    tick(3);
    check("full_pushpop_ovf", 32'(overflow), 32'(exp_ovf));
    p0 = pops;
    set_ready(1'b1);
    tick(8);
    set_ready(1'b0);
    check("full_drain_count", 32'(pops - p0), 32'(DEPTH));
    check("full_drain_left", 32'(exp_q.size()), 32'd0);
    check("full_drain_valid", 32'(bus_if.ev_valid), 32'd0);

    // Reset while the clear write is on the bus
    ops.delete();
    issue_event(10'h021, 1'b0, 1'b0);
    tick(4);
    check("clr_cs_before_rst", 32'(bus_if.pio_chipselect), 32'd1);
    check("clr_wn_before_rst", 32'(bus_if.pio_write_n), 32'd0);
    reset = 1'b1;
    tick(1);
    check("midrst_cs", 32'(bus_if.pio_chipselect), 32'd0);
    check("midrst_write_n", 32'(bus_if.pio_write_n), 32'd1);
    check("midrst_addr", 32'(bus_if.pio_address), 32'd0);
    check("midrst_wdata", bus_if.pio_writedata, 32'd0);
    check("midrst_valid", 32'(bus_if.ev_valid), 32'd0);
    tick(2);
    ops.delete();
    reset = 1'b0;
    c0 = cyc;
    tick(6);
    check_mask_write(c0);
    check("postrst_valid", 32'(bus_if.ev_valid), 32'd0);

    // Randomized events with a random-ready consumer
    rand_mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue_event(W'($urandom_range(1, 1023)), 1'b0, 1'b1);
      tick($urandom_range(9, 14));
    end
    rand_mode = 1'b0;
    set_ready(1'b1);
    tick(12);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_overflow", 32'(overflow), 32'(exp_ovf));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
